// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/control logic.
//   hz_state_t   : control FSM states
//   REG_ADDR_W   : architectural register index width
//   is_load_use  : load-use hazard test, also used by the forwarding unit
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_FLUSH
  } hz_state_t;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  function automatic logic is_load_use(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs1,
    input logic                  use_rs2
  );
    return mem_read && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-low reset
//   clr        : restart the count; if inc is also high the new count is 1
//   inc        : count up by one, holding at MAX
//   count      : current value
module sat_counter #(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      // clr+inc starts a fresh run that already includes this cycle
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Sources: load-use hazards in ID, taken branches resolved in EX, and
// data-memory wait states. Control outputs are decoded combinationally from
// the registered FSM state plus current inputs; only the state, counters and
// mem_timeout are registered.
//   clk, reset          : clock, synchronous active-low reset
//   id_rs1/id_rs2       : ID source registers, id_use_rs1/2 qualify them
//   ex_rd, ex_mem_read  : EX destination and load flag
//   ex_branch_taken     : EX redirects the PC
//   mem_req, mem_ready  : MEM access in flight / completing this cycle
//   pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall : controls
//   mem_timeout         : one-cycle pulse after MEM_TIMEOUT wait cycles
//   stall_count         : saturating count of pc_stall cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int unsigned      TMO_W        = 16;
  localparam int unsigned      FL_W         = 3;
  localparam logic [TMO_W-1:0] TMO_MAX      = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(MEM_TIMEOUT - 1);
  localparam bit               TMO_ONE      = (MEM_TIMEOUT == 1);
  localparam bit               MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [FL_W-1:0]  FLUSH_RELOAD = FL_W'(FLUSH_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             load_use;
  logic             mem_wait;

  assign load_use = is_load_use(ex_mem_read, ex_rd, id_rs1, id_rs2,
                                id_use_rs1, id_use_rs2);
  assign mem_wait = mem_req & ~mem_ready;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    tmo_hit      = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          flush_cnt_d  = '0;
          if (TMO_ONE) tmo_hit = 1'b1;
          else         state_d = S_MEM_WAIT;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (MULTI_FLUSH) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end

      // Flushes stay low while frozen: a flush would wipe the held registers.
      S_MEM_WAIT: begin
        if (mem_wait) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          if (tmo_cnt == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end

      // ID holds a wrong-path instruction here, so load-use is not considered.
      S_FLUSH: begin
        if (mem_wait) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          flush_cnt_d  = '0;
          if (TMO_ONE) begin
            tmo_hit = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_cnt_d = FLUSH_RELOAD;
        end else begin
          if_id_flush = 1'b1;
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FL_W'(1)) state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mem_timeout <= tmo_hit;
    end
  end

  // Counts consecutive wait cycles; the entry cycle (outside S_MEM_WAIT)
  // restarts the run at 1 via clr+inc.
  sat_counter #(
    .WIDTH (TMO_W),
    .MAX   (TMO_MAX)
  ) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != S_MEM_WAIT),
    .inc   (mem_wait),
    .count (tmo_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (pc_stall),
    .count (stall_count)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline-control unit for the 5-stage core. Generates the stall/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers from three sources:
- load-use hazards detected in ID;
- taken branches/jumps resolved in EX;
- data-memory wait states.
A small FSM sequences multi-cycle flush windows and memory freezes, with a wait timeout and a saturating stall-cycle counter for performance monitoring.

Parameters:
FLUSH_CYCLES, 1, IF/ID flush cycles after a taken branch (1..7); >1 covers fetch latency.
MEM_TIMEOUT, 255, max consecutive memory-wait cycles before mem_timeout pulses (1..65535).
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump (redirect PC)
mem_req  in  1  MEM stage has an access in flight
mem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  insert bubble into ID/EX
ex_mem_stall  out  1  hold ID/EX and EX/MEM (memory freeze)
mem_timeout  out  1  one-cycle pulse: wait exceeded MEM_TIMEOUT
stall_count  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (reset=0 at clk edge):
  - state=S_RUN; flush and timeout counters=0; stall_count=0; mem_timeout=0.
  - All control outputs are combinational from state and inputs, so all are 0 while in S_RUN with idle inputs.
- Outputs are decoded combinationally from the registered state plus current inputs, so the response is in the same cycle. Only state, counters and mem_timeout are registered.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mem_wait = mem_req & ~mem_ready.
- Priority in S_RUN, highest first: mem_wait > ex_branch_taken > load_use.
- S_RUN:
  - mem_wait: assert pc_stall, if_id_stall, ex_mem_stall; no flushes. Next state S_MEM_WAIT, timeout counter=1.
  - else ex_branch_taken: assert if_id_flush, id_ex_flush. If FLUSH_CYCLES>1, next state S_FLUSH with flush counter=FLUSH_CYCLES-1.
  - else load_use: assert pc_stall, if_id_stall, id_ex_flush for exactly this cycle. The inserted bubble clears the condition next cycle. Stay in S_RUN.
- S_MEM_WAIT:
  - pc_stall, if_id_stall, ex_mem_stall held high.
  - if_id_flush=0 and id_ex_flush=0 always: flush has priority over stall in the pipeline registers and would destroy held state.
  - mem_ready=1: stalls drop that same cycle; next state S_RUN. A branch or load-use still present is handled normally in the following cycle.
  - Timeout counter increments each wait cycle, saturating at MEM_TIMEOUT. When it reaches MEM_TIMEOUT: mem_timeout pulses high for 1 cycle, then the FSM returns to S_RUN and stalls release. Recovery is the trap logic's responsibility.
- S_FLUSH:
  - Assert if_id_flush only; decrement the counter; return to S_RUN when the counter reaches 0.
  - load_use is ignored because the ID instruction is wrong-path.
  - A new ex_branch_taken reloads the counter to FLUSH_CYCLES-1 and asserts id_ex_flush.
  - mem_wait preempts: go to S_MEM_WAIT; the remaining flush count is discarded. Wrong-path IF/ID content is killed by the EX redirect, which is already done.
- stall_count increments on every cycle with pc_stall=1 and saturates at 2^CNT_W-1 without wrapping.
- Reset mid-wait or mid-flush: state, counters and the mem_timeout pulse all clear at that edge.
- Register x0 never produces a hazard.

Decomposition:
- Package hazard_pkg:
  - typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FLUSH} hz_state_t;
  - REG_ADDR_W=5;
  - function is_load_use(...) for reuse by the forwarding unit.
- One sub-module: sat_counter (parameterised width, inc, clr, saturate), instantiated for stall_count and the timeout counter.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1.
  - Response: same cycle pc_stall=if_id_stall=id_ex_flush=1. Next cycle with ex_mem_read=0, all 0. stall_count=1.
- x0 guard:
  - Stimulus: ex_rd=0, id_rs1=0, ex_mem_read=1.
  - Response: no stall, no flush.
- Branch with FLUSH_CYCLES=3:
  - Stimulus: ex_branch_taken pulse.
  - Response: cycle 0 has if_id_flush=id_ex_flush=1. Cycles 1-2 have if_id_flush=1 only. Cycle 3 all 0.
- Memory freeze:
  - Stimulus: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1, with ex_branch_taken=1 throughout.
  - Response: 4 cycles of pc_stall=if_id_stall=ex_mem_stall=1 with both flushes 0. Release on the mem_ready cycle. Branch flush the next cycle. stall_count=4.
- Timeout with MEM_TIMEOUT=8:
  - Stimulus: mem_ready held 0.
  - Response: mem_timeout pulses exactly once at the 8th wait cycle, then the FSM is back in S_RUN.
- Reset mid-S_FLUSH and saturation (CNT_W=4):
  - Stimulus 1: reset=0 one edge during S_FLUSH. Response: all outputs 0 and stall_count=0 next cycle.
  - Stimulus 2: 20 stall cycles. Response: stall_count holds 15.
